// File: rtl/bus_fault_monitor_pkg.sv
// Shared bus definitions: address width, access-size encodings and fault cause codes.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package bus_fault_monitor_pkg;

    localparam int XLEN        = 32;
    localparam int BUS_ACC_CNT = 3;
    localparam int ACC_W       = $clog2(BUS_ACC_CNT);

    typedef logic [ACC_W-1:0] acc_t;
    typedef logic [7:0]       cause_t;

    localparam acc_t ACC_BYTE = acc_t'(0);
    localparam acc_t ACC_HALF = acc_t'(1);
    localparam acc_t ACC_WORD = acc_t'(2);

    localparam cause_t FAULT_NONE     = 8'h00;
    localparam cause_t FAULT_SLV      = 8'h01;
    localparam cause_t FAULT_TMO      = 8'h02;
    localparam cause_t FAULT_MISALIGN = 8'h03;
    localparam cause_t FAULT_BADACC   = 8'h04;
    localparam cause_t FAULT_STRAY    = 8'h05;

    // Natural alignment: halves need addr[0]=0, words need addr[1:0]=0.
    function automatic logic acc_misaligned(input acc_t acc, input logic [1:0] addr_lo);
        logic r;
        r = 1'b0;
        case (acc)
            ACC_HALF: r = addr_lo[0];
            ACC_WORD: r = (addr_lo != 2'b00);
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bus_fault_monitor_if.sv
// Core-side system bus request/response signals as seen by the fault monitor.
// Latency: n/a (wiring only).
// Backpressure: none; the bus has no stall path through this interface.
interface bus_fault_monitor_if;
    import bus_fault_monitor_pkg::*;

    logic [XLEN-1:0] m_addr;
    logic            m_w_rb;
    acc_t            m_acc;
    logic            m_req;
    logic            m_resp;
    logic            m_fault;

    modport master (
        output m_addr, m_w_rb, m_acc, m_req, m_resp, m_fault
    );

    modport slave (
        input m_addr, m_w_rb, m_acc, m_req, m_resp, m_fault
    );

endinterface

// File: rtl/bus_fault_monitor_access_check.sv
// Classifies one bus access as an illegal size or a misaligned address.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module bus_access_check
    import bus_fault_monitor_pkg::*;
(
    input  logic [1:0] i_addr,
    input  acc_t       i_acc,
    output logic       o_bad_acc,
    output logic       o_misalign
);

    // Only the low address bits matter for alignment of sizes up to a word.
    assign o_bad_acc  = (int'(i_acc) >= BUS_ACC_CNT);
    assign o_misalign = acc_misaligned(i_acc, i_addr);

endmodule

// File: rtl/bus_fault_monitor.sv
// Passive bus observer reporting slave faults, timeouts, bad/misaligned accesses, stray responses.
// Latency: 1 cycle from the detecting edge to the soc_fault pulse.
// Backpressure: none; never drives or stalls the bus.
module bus_fault_monitor
    import bus_fault_monitor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_fault_monitor_if.slave   bus,
    output logic                 soc_fault,
    output cause_t               soc_fault_cause,
    output logic [XLEN-1:0]      soc_fault_addr,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

    logic [1:0]       r_state;
    logic [TMR_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_addr;
    logic             r_fault;
    cause_t           r_cause;
    logic [XLEN-1:0]  r_faddr;

    logic [1:0]       w_state_nxt;
    logic [TMR_W-1:0] w_cnt_nxt;
    logic [XLEN-1:0]  w_addr_nxt;
    logic             w_report;
    cause_t           w_cause;
    logic [XLEN-1:0]  w_rep_addr;
    logic             w_bad_acc;
    logic             w_misalign;
    logic             w_unused;

    // Transfer direction does not influence any fault class.
    assign w_unused = bus.m_w_rb;

    bus_access_check u_acc_chk (
        .i_addr     (bus.m_addr[1:0]),
        .i_acc      (bus.m_acc),
        .o_bad_acc  (w_bad_acc),
        .o_misalign (w_misalign)
    );

    // Next-state, counter and report decode; a new request is judged by the access checker.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_report    = 1'b0;
        w_cause     = FAULT_NONE;
        w_rep_addr  = r_addr;
        case (r_state)
            S_WAIT: begin
                if (bus.m_resp) begin
                    w_state_nxt = S_IDLE;
                    if (bus.m_fault) begin
                        w_report = 1'b1;
                        w_cause  = FAULT_SLV;
                    end
                    // Back-to-back: the completing response frees the monitor for a new request.
                    // An old-transaction slave fault takes the single report slot.
                    if (bus.m_req) begin
                        w_addr_nxt = bus.m_addr;
                        w_cnt_nxt  = '0;
                        if (w_bad_acc || w_misalign) begin
                            if (!bus.m_fault) begin
                                w_report   = 1'b1;
                                w_cause    = w_bad_acc ? FAULT_BADACC : FAULT_MISALIGN;
                                w_rep_addr = bus.m_addr;
                            end
                        end else begin
                            w_state_nxt = S_WAIT;
                        end
                    end
                end else if (r_cnt == TMO_LAST) begin
                    w_report    = 1'b1;
                    w_cause     = FAULT_TMO;
                    w_state_nxt = S_DRAIN;
                end else if (r_cnt != TMR_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                // IDLE and DRAIN accept requests identically; only IDLE treats a response as stray.
                if (bus.m_req) begin
                    w_addr_nxt = bus.m_addr;
                    w_cnt_nxt  = '0;
                    if (w_bad_acc) begin
                        w_report    = 1'b1;
                        w_cause     = FAULT_BADACC;
                        w_rep_addr  = bus.m_addr;
                        w_state_nxt = S_IDLE;
                    end else if (w_misalign) begin
                        w_report    = 1'b1;
                        w_cause     = FAULT_MISALIGN;
                        w_rep_addr  = bus.m_addr;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WAIT;
                        if (bus.m_resp && (r_state == S_IDLE)) begin
                            w_report = 1'b1;
                            w_cause  = FAULT_STRAY;
                        end
                    end
                end else if (bus.m_resp) begin
                    w_state_nxt = S_IDLE;
                    if (r_state == S_IDLE) begin
                        w_report = 1'b1;
                        w_cause  = FAULT_STRAY;
                    end
                end
            end
        endcase
    end

    // Transaction tracking state: FSM, timeout counter and latched request address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Report register: one-cycle pulse, cause and address held until the next report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
            r_cause <= FAULT_NONE;
            r_faddr <= '0;
        end else begin
            r_fault <= w_report;
            if (w_report) begin
                r_cause <= w_cause;
                r_faddr <= w_rep_addr;
            end
        end
    end

    assign soc_fault       = r_fault;
    assign soc_fault_cause = r_cause;
    assign soc_fault_addr  = r_faddr;
    assign busy            = (r_state == S_WAIT);

endmodule

// File: tb/tb_bus_fault_monitor.sv
// Bench for bus_fault_monitor: directed scenarios plus random bus traffic against a reference model.
// Latency: expected reports are scheduled one cycle after the sampling edge.
// Backpressure: none; the monitor process checks every soc_fault pulse against the queue.
module tb_bus_fault_monitor;
    import bus_fault_monitor_pkg::*;

    localparam int T = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            soc_fault;
    cause_t          soc_fault_cause;
    logic [XLEN-1:0] soc_fault_addr;
    logic            busy;

    bus_fault_monitor_if bus ();

    bus_fault_monitor #(.TIMEOUT_CYCLES(T)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .soc_fault       (soc_fault),
        .soc_fault_cause (soc_fault_cause),
        .soc_fault_addr  (soc_fault_addr),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          cyc;
        logic [7:0]  cause;
        logic [31:0] addr;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: a live transaction, how long it has waited, whether a timed-out one is draining.
    bit          m_pending  = 1'b0;
    bit          m_draining = 1'b0;
    int          m_waited   = 0;
    logic [31:0] m_last     = '0;
    bit          m_busy     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic accept(input logic [31:0] addr, input int acc, inout bit rep,
                          inout logic [7:0] c, inout logic [31:0] a);
        m_last     = addr;
        m_draining = 1'b0;
        if (acc >= 3) begin
            if (!rep) begin rep = 1'b1; c = 8'h04; a = addr; end
        end else if ((acc == 1 && addr % 2 != 0) || (acc == 2 && addr % 4 != 0)) begin
            if (!rep) begin rep = 1'b1; c = 8'h03; a = addr; end
        end else begin
            m_pending = 1'b1;
            m_waited  = 0;
        end
    endtask

    task automatic model_step(input bit req, input logic [31:0] addr, input int acc,
                              input bit resp, input bit fault);
        bit          rep = 1'b0;
        logic [7:0]  c   = 8'h00;
        logic [31:0] a   = 32'h0;
        logic [31:0] old = m_last;
        bit          stray;
        if (m_pending) begin
            if (resp) begin
                m_pending = 1'b0;
                if (fault) begin rep = 1'b1; c = 8'h01; a = old; end
                if (req) accept(addr, acc, rep, c, a);
            end else begin
                m_waited++;
                if (m_waited == T) begin
                    rep = 1'b1; c = 8'h02; a = old;
                    m_pending  = 1'b0;
                    m_draining = 1'b1;
                end
            end
        end else begin
            stray = resp && !m_draining;
            if (req) accept(addr, acc, rep, c, a);
            else if (resp) m_draining = 1'b0;
            if (stray && !rep) begin rep = 1'b1; c = 8'h05; a = old; end
        end
        m_busy = m_pending;
        if (rep) q.push_back('{cyc + 1, c, a});
    endtask

    task automatic step(input bit req, input logic [31:0] addr, input int acc,
                        input bit resp, input bit fault);
        @(negedge clk);
        check("busy", 32'(busy), 32'(m_busy));
        bus.m_req   = req;
        bus.m_addr  = addr;
        bus.m_acc   = acc[ACC_W-1:0];
        bus.m_w_rb  = 1'($urandom_range(0, 1));
        bus.m_resp  = resp;
        bus.m_fault = fault;
        model_step(req, addr, acc, resp, fault);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 0, 1'b0, 1'b0);
    endtask

    // Monitor: every pulse must match the oldest expectation, and nothing expected may be skipped.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_report: got no soc_fault expected cause %h addr %h at cycle %0d",
                         q[0].cause, q[0].addr, q[0].cyc);
                void'(q.pop_front());
            end
            if (soc_fault) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_report: got cause %h addr %h expected no soc_fault (cycle %0d)",
                             soc_fault_cause, soc_fault_addr, cyc);
                end else begin
                    e = q.pop_front();
                    check("report_cycle", 32'(cyc), 32'(e.cyc));
                    check("report_cause", 32'(soc_fault_cause), 32'(e.cause));
                    check("report_addr", soc_fault_addr, e.addr);
                end
            end
        end
    end

    initial begin : stimulus
        int          acc;
        logic [31:0] a;
        rst         = 1'b1;
        bus.m_req   = 1'b0;
        bus.m_addr  = '0;
        bus.m_acc   = '0;
        bus.m_w_rb  = 1'b0;
        bus.m_resp  = 1'b0;
        bus.m_fault = 1'b0;
        #22;
        check("rst_soc_fault", 32'(soc_fault), 32'h0);
        check("rst_cause", 32'(soc_fault_cause), 32'h0);
        check("rst_addr", soc_fault_addr, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Clean word read, response three cycles after the request.
        step(1'b1, 32'h0000_1000, 2, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 32'h0, 0, 1'b1, 1'b0);
        idle(3);

        // Word write answered with a slave fault.
        step(1'b1, 32'h0000_2004, 2, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 32'h0, 0, 1'b1, 1'b1);
        idle(3);

        // No response: timeout, then a late response is drained silently.
        step(1'b1, 32'h0000_3000, 2, 1'b0, 1'b0);
        idle(19);
        step(1'b0, 32'h0, 0, 1'b1, 1'b0);
        idle(3);

        // Access-size errors, each reported one cycle after the request.
        step(1'b1, 32'h0000_0011, 1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0012, 2, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0050, 3, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 32'h0, 0, 1'b1, 1'b0);
        idle(2);

        // Stray response after a good transaction to 0x40, then back-to-back into 0x44.
        step(1'b1, 32'h0000_0040, 2, 1'b0, 1'b0);
        step(1'b0, 32'h0, 0, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 32'h0, 0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0040, 2, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0044, 2, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 32'h0, 0, 1'b1, 1'b0);
        idle(2);

        // Response on the exact timeout cycle wins.
        step(1'b1, 32'h0000_6000, 0, 1'b0, 1'b0);
        idle(T - 1);
        step(1'b0, 32'h0, 0, 1'b1, 1'b0);
        idle(3);

        // Reset asserted in WAIT one cycle before the timeout would fire.
        step(1'b1, 32'h0000_5000, 2, 1'b0, 1'b0);
        idle(T - 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_soc_fault", 32'(soc_fault), 32'h0);
        check("midrst_cause", 32'(soc_fault_cause), 32'h0);
        check("midrst_addr", soc_fault_addr, 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        m_pending  = 1'b0;
        m_draining = 1'b0;
        m_waited   = 0;
        m_last     = '0;
        m_busy     = 1'b0;
        q.delete();
        bus.m_req  = 1'b0;
        bus.m_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(T + 2);

        // Random traffic, mostly well-formed word accesses.
        for (int i = 0; i < 3000; i++) begin
            a   = $urandom & 32'h0000_FFFC;
            acc = 2;
            if ($urandom_range(0, 3) == 0) begin
                acc = $urandom_range(0, 3);
                a   = a | 32'($urandom_range(0, 3));
            end
            step(1'($urandom_range(0, 3) == 0), a, acc,
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0));
        end
        idle(T + 4);
        check("queue_empty", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_fault_monitor.md
Name: bus_fault_monitor

Overview:
- Passive observer on the core-side system bus, upstream of the reset controller.
- Detects four bus error classes on every transaction: slave-reported faults, response timeouts, misaligned or illegal access sizes, and unsolicited responses.
- On detection it produces the soc_fault / soc_fault_cause / soc_fault_addr triple that the reset controller consumes.
- Never drives or stalls the bus.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait after a request before declaring a timeout. Legal range 1..65535.
- TMR_W, $clog2(TIMEOUT_CYCLES+1): width of the timeout counter. Derived; do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m_addr  in  `XLEN  byte address of the observed request
- m_w_rb  in  1  1 = write, 0 = read
- m_acc  in  $clog2(`BUS_ACC_CNT)  access size: 0 = byte, 1 = half, 2 = word, others illegal
- m_req  in  1  single-cycle request strobe
- m_resp  in  1  single-cycle response strobe
- m_fault  in  1  slave fault; valid only when m_resp=1
- soc_fault  out  1  single-cycle fault pulse
- soc_fault_cause  out  8  cause code of the last reported fault
- soc_fault_addr  out  `XLEN  address of the last reported fault
- busy  out  1  a transaction is outstanding

Behaviour:
- Reset values: soc_fault=0, soc_fault_cause=8'h00, soc_fault_addr=0, busy=0, state=IDLE, timeout counter=0.
- Cause codes (8 bits):
  - 8'h01 SLV_FAULT: m_resp && m_fault.
  - 8'h02 TIMEOUT: no m_resp within TIMEOUT_CYCLES.
  - 8'h03 MISALIGN: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - 8'h04 BAD_ACC: m_acc >= `BUS_ACC_CNT.
  - 8'h05 STRAY_RESP: m_resp while IDLE.
- State machine:
  - IDLE:
    - On m_req: latch m_addr, clear the counter, go to WAIT.
    - If the access is MISALIGN or BAD_ACC, report it in the same latch cycle, stay in IDLE, and treat the transaction as dead (a later m_resp is STRAY_RESP).
    - BAD_ACC has priority over MISALIGN.
  - WAIT:
    - busy=1; the counter increments every cycle.
    - m_resp with m_fault=0: go to IDLE, no report.
    - m_resp with m_fault=1: report SLV_FAULT with the latched address, go to IDLE.
    - Counter reaching TIMEOUT_CYCLES-1 without m_resp: report TIMEOUT, go to DRAIN.
    - m_req in WAIT is a protocol violation; ignore it (no report, address not relatched).
  - DRAIN:
    - Waits for the late response.
    - m_resp: go to IDLE silently.
    - m_req: treat as the IDLE entry (late response is abandoned).
- Reporting rules:
  - A report registers soc_fault=1 for exactly one cycle, on the cycle after the detecting edge (latency 1).
  - soc_fault_cause and soc_fault_addr update on that same edge and hold until the next report.
- Boundary conditions:
  - m_resp and m_req in the same cycle while in WAIT: complete the current transaction, then accept the new request (back-to-back). Next state is WAIT with the new address. Any SLV_FAULT for the old transaction is still reported.
  - TIMEOUT_CYCLES=1: timeout fires if m_resp is absent on the first WAIT cycle.
  - A response arriving on the exact timeout cycle wins. No TIMEOUT is reported.
  - STRAY_RESP reports the last latched address.
- Reset mid-transaction: all state clears asynchronously and any in-flight report is dropped.
- Counter width: TMR_W bits, saturating. It never wraps.

Decomposition:
- Shared package/header `femto.vh` gains:
  - Cause constants FAULT_SLV, FAULT_TMO, FAULT_MISALIGN, FAULT_BADACC, FAULT_STRAY.
  - Access-size constants ACC_BYTE, ACC_HALF, ACC_WORD.
- One natural sub-module, bus_access_check. It is combinational: inputs addr and acc, outputs bad_acc and misalign. It is reusable by other bus masters.
- The FSM, counter and report register stay in bus_fault_monitor.

Test Plan:
- Word read to 0x0000_1000, m_resp 3 cycles later, m_fault=0 -> soc_fault stays 0, busy high for 3 cycles.
- Word write to 0x0000_2004, m_resp with m_fault=1 -> one-cycle soc_fault, cause 8'h01, addr 0x0000_2004.
- TIMEOUT_CYCLES=8, req to 0x0000_3000, no resp -> soc_fault on cycle 9 after req, cause 8'h02, addr 0x0000_3000; resp at cycle 20 -> no report, busy=0.
- Half access to 0x0000_0011 -> cause 8'h03. Word access to 0x0000_0012 -> cause 8'h03. m_acc=3 -> cause 8'h04. Each is reported one cycle after req.
- m_resp while idle after a prior good transaction to 0x40 -> cause 8'h05, addr 0x40. Back-to-back m_resp+m_req to 0x44 -> busy stays 1, no report.
- Assert rst during WAIT at timeout-1 -> no soc_fault, all outputs return to reset values immediately.
